matmul_host_seq: RTL

MATMUL_HOST_SEQ -- requirements
Module: matmul_host_seq

---
 rtl/matmul_host_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/matmul_host_seq.sv
`default_nettype none
// =============================================================================
// Module      : matmul_host_seq
// Description : Job sequencer for a matmul control path. It accepts one request,
//               holds start while the job runs and reports the id, the BUSY cycle
//               count and a timeout flag. Defining MATMUL_SEQ_TIMEOUT_EN enables
//               the BUSY watchdog.
// Revision    : 1.0 - initial release
// =============================================================================
module matmul_host_seq #(
    parameter int K       = 2,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [ID_W-1:0] req_id,
    output logic            start,
    input  logic            done,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [ID_W-1:0] resp_id,
    output logic            resp_err,
    output logic [15:0]     resp_cycles,
    output logic            busy,
    output logic [15:0]     job_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    // Bad configurations are rejected at elaboration time.
    generate
        if (K < 1 || TIMEOUT < 1 || TIMEOUT > 65535 || ID_W < 1) begin : g_param_check
            $error("matmul_host_seq: invalid parameter set");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_id;
    logic [15:0]       r_cycles;
    logic [15:0]       w_cycles_inc;
    logic              r_start;
    logic [15:0]       r_job_count;
    logic              w_timeout;
    logic              w_accept;

    assign w_cycles_inc = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;
    assign w_accept     = (r_state == S_IDLE) && req_valid && !done;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    logic r_err;
    // done has priority: a timeout only counts when done is low that cycle.
    assign w_timeout = (r_state == S_BUSY) && !done && (w_cycles_inc >= c_TIMEOUT);
    assign resp_err  = r_err;
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:    if (done || w_timeout) w_state_nxt = S_RELEASE;
            S_RELEASE: if (!done) w_state_nxt = S_RESP;
            S_RESP:    if (resp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_id        <= '0;
            r_cycles    <= 16'd0;
            r_job_count <= 16'd0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_start <= (w_state_nxt == S_BUSY);
            if (w_accept) begin
                r_id     <= req_id;
                r_cycles <= 16'd0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                r_err    <= 1'b0;
`endif
            end
            if (r_state == S_BUSY) begin
                r_cycles <= w_cycles_inc;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                if (w_timeout) r_err <= 1'b1;
`endif
            end
            if (r_state == S_RESP && resp_ready) begin
                r_job_count <= r_job_count + 16'd1;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE) && !done;
    assign start       = r_start;
    assign resp_valid  = (r_state == S_RESP);
    assign resp_id     = r_id;
    assign resp_cycles = r_cycles;
    assign busy        = (r_state != S_IDLE);
    assign job_count   = r_job_count;

endmodule
`default_nettype wire
